// File: rtl/ram_imagen_arbiter.sv
// Purpose : single-port frame-buffer access controller; camera writes vs bus reads.
// Latency : write lands 1 cycle after acceptance; read ack 4 cycles from grant.
// Backpres: cam_ready low outside IDLE or when a read wins; rd_req held until ack.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), async active-high reset
//   cam_vsync_i         frame start: next write goes to address 0
//   cam_valid_i/dat_i   capture pixel stream; cam_ready_o = pixel taken this cycle
//   rd_req_i/adr_i      bus read request, held until rd_ack_o
//   rd_ack_o/dat_o      one-cycle read-done pulse; rd_dat_o held until next ack
//   ram_we_o/re_o       registered RAM write enable / read strobe
//   ram_adr_o/dat_o     registered RAM address / write data
//   ram_dat_i           RAM read data, valid the cycle after ram_re_o
//   wr_adr_o            next capture write address
//   frame_done_o        pulse after the last word of a frame has been written
module ram_imagen_arbiter #(
  parameter int ADR_W      = 19,
  parameter int DAT_W      = 8,
  parameter int WORD_DEPTH = 307200,
  parameter int MAX_WAIT   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cam_vsync_i,
  input  logic             cam_valid_i,
  input  logic [DAT_W-1:0] cam_dat_i,
  output logic             cam_ready_o,
  input  logic             rd_req_i,
  input  logic [ADR_W-1:0] rd_adr_i,
  output logic             rd_ack_o,
  output logic [DAT_W-1:0] rd_dat_o,
  output logic             ram_we_o,
  output logic             ram_re_o,
  output logic [ADR_W-1:0] ram_adr_o,
  output logic [DAT_W-1:0] ram_dat_o,
  input  logic [DAT_W-1:0] ram_dat_i,
  output logic [ADR_W-1:0] wr_adr_o,
  output logic             frame_done_o
);

  typedef enum logic [1:0] {IDLE, WR, RD, RDW} state_t;

  localparam int SW = $clog2(MAX_WAIT + 1);
  localparam logic [ADR_W-1:0] LAST_ADR   = ADR_W'(WORD_DEPTH - 1);
  localparam logic [SW-1:0]    STARVE_MAX = SW'(MAX_WAIT);

  state_t           state;
  logic [SW-1:0]    starve;   // consecutive write grants while a read waits
  logic             rd_ok;
  logic             rd_grant;
  logic             wr_grant;
  logic [ADR_W-1:0] use_adr;

  // Grant decision. rd_ok masks the request during the ack cycle so a
  // requester that has not yet dropped rd_req is not served twice.
  always_comb begin
    rd_ok    = rd_req_i & ~rd_ack_o;
    rd_grant = (state == IDLE) & rd_ok & (~cam_valid_i | (starve == STARVE_MAX));
    wr_grant = (state == IDLE) & cam_valid_i & ~rd_grant;
    use_adr  = cam_vsync_i ? '0 : wr_adr_o;
  end

  assign cam_ready_o = wr_grant;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      starve       <= '0;
      rd_ack_o     <= 1'b0;
      rd_dat_o     <= '0;
      ram_we_o     <= 1'b0;
      ram_re_o     <= 1'b0;
      ram_adr_o    <= '0;
      ram_dat_o    <= '0;
      wr_adr_o     <= '0;
      frame_done_o <= 1'b0;
    end else begin
      rd_ack_o     <= 1'b0;
      frame_done_o <= 1'b0;

      // Capture address: advance past the address actually used, wrapping
      // at the end of the frame; a lone vsync just rewinds to 0.
      if (wr_grant) begin
        if (use_adr == LAST_ADR) begin
          wr_adr_o     <= '0;
          frame_done_o <= 1'b1;
        end else begin
          wr_adr_o <= use_adr + 1'b1;
        end
      end else if (cam_vsync_i) begin
        wr_adr_o <= '0;
      end

      case (state)
        IDLE: begin
          if (rd_grant) begin
            ram_re_o  <= 1'b1;
            ram_adr_o <= rd_adr_i;
            starve    <= '0;
            state     <= RD;
          end else if (wr_grant) begin
            ram_we_o  <= 1'b1;
            ram_adr_o <= use_adr;
            ram_dat_o <= cam_dat_i;
            // Only count writes that actually kept a reader waiting.
            starve    <= rd_ok ? starve + 1'b1 : '0;
            state     <= WR;
          end
        end
        WR: begin
          ram_we_o <= 1'b0;
          state    <= IDLE;
        end
        RD: begin
          ram_re_o <= 1'b0;
          state    <= RDW;
        end
        RDW: begin
          rd_dat_o <= ram_dat_i;
          rd_ack_o <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_imagen_arbiter.sv
// Bench for ram_imagen_arbiter: directed steps followed by a randomized run
// against a transaction-level model (expected memory image, write pointer,
// starvation bound). The frame depth is shrunk so wraps happen quickly.
module tb_ram_imagen_arbiter;

  localparam int ADR_W    = 19;
  localparam int DAT_W    = 8;
  localparam int D        = 128;
  localparam int IW       = 7;
  localparam int MAX_WAIT = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cam_vsync, cam_valid, cam_ready;
  logic [DAT_W-1:0] cam_dat;
  logic             rd_req, rd_ack;
  logic [ADR_W-1:0] rd_adr;
  logic [DAT_W-1:0] rd_dat;
  logic             ram_we, ram_re;
  logic [ADR_W-1:0] ram_adr, wr_adr;
  logic [DAT_W-1:0] ram_wdat;
  logic [DAT_W-1:0] ram_rdat = '0;
  logic             frame_done;

  // Frame buffer RAM model with a preload port for directed setup.
  bit   [7:0]       ram_mem [0:1023];
  logic             pre_we;
  logic [9:0]       pre_adr;
  logic [7:0]       pre_dat;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_imagen_arbiter #(
    .ADR_W(ADR_W), .DAT_W(DAT_W), .WORD_DEPTH(D), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cam_vsync_i(cam_vsync), .cam_valid_i(cam_valid), .cam_dat_i(cam_dat),
    .cam_ready_o(cam_ready),
    .rd_req_i(rd_req), .rd_adr_i(rd_adr), .rd_ack_o(rd_ack), .rd_dat_o(rd_dat),
    .ram_we_o(ram_we), .ram_re_o(ram_re), .ram_adr_o(ram_adr),
    .ram_dat_o(ram_wdat), .ram_dat_i(ram_rdat),
    .wr_adr_o(wr_adr), .frame_done_o(frame_done)
  );

  always @(posedge clk) begin
    if (pre_we)      ram_mem[pre_adr] <= pre_dat;
    else if (ram_we) ram_mem[ram_adr[9:0]] <= ram_wdat;
    if (ram_re)      ram_rdat <= ram_mem[ram_adr[9:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer one pixel and hold it until accepted; returns in the cycle after acceptance.
  task automatic push(input logic [7:0] d, input logic vs, output bit ok);
    ok        = 1'b0;
    cam_valid = 1'b1;
    cam_dat   = d;
    cam_vsync = vs;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (cam_ready) ok = 1'b1;
      cyc();
    end
    cam_valid = 1'b0;
    cam_vsync = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]       pix [0:2];
    bit   [7:0]       ref_mem [0:D-1];
    logic [5:0]       we_vec;
    logic [ADR_W-1:0] exp_wr, used, prev_used;
    logic [7:0]       prev_dat;
    logic             acc, prev_acc, hold, ack_seen;
    bit               ok;
    int               k, grant_at, post, acks, n_ok, wcnt, wait_c, reads_done;

    pix[0] = 8'h11; pix[1] = 8'h22; pix[2] = 8'h33;
    rst = 1'b1; cam_vsync = 0; cam_valid = 0; cam_dat = 0; rd_req = 0; rd_adr = 0;
    pre_we = 1'b1; pre_adr = 10'd5; pre_dat = 8'hA5;
    cyc();
    pre_we = 1'b0;

    // Reset state
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_re", ram_re, 0);
    check("rst_ram_adr", ram_adr, 0);
    check("rst_ram_dat", ram_wdat, 0);
    check("rst_rd_ack", rd_ack, 0);
    check("rst_rd_dat", rd_dat, 0);
    check("rst_wr_adr", wr_adr, 0);
    check("rst_frame_done", frame_done, 0);
    @(negedge clk) rst = 1'b0;
    cyc();

    // Stream three pixels with no reader: one write every other cycle
    k = 0; we_vec = '0;
    for (int c = 0; c < 6; c++) begin
      cam_valid = (k < 3);
      cam_dat   = pix[k % 3];
      #1;
      if (cam_ready) k++;
      cyc();
      we_vec[c] = ram_we;
    end
    cam_valid = 1'b0;
    check("stream_accepted", k, 3);
    check("stream_we_pattern", we_vec, 6'b010101);
    check("stream_mem0", ram_mem[0], 8'h11);
    check("stream_mem1", ram_mem[1], 8'h22);
    check("stream_mem2", ram_mem[2], 8'h33);
    check("stream_wr_adr", wr_adr, 3);

    // Single read, idle writer: strobe next cycle, ack on the 4th cycle
    rd_req = 1'b1; rd_adr = 5;
    cyc();
    check("rd_re_c1", ram_re, 1);
    check("rd_adr_c1", ram_adr, 5);
    check("rd_ack_c1", rd_ack, 0);
    cyc();
    check("rd_re_c2", ram_re, 0);
    check("rd_ack_c2", rd_ack, 0);
    cyc();
    check("rd_ack_c3", rd_ack, 1);
    check("rd_dat_c3", rd_dat, 8'hA5);
    rd_req = 1'b0;
    cyc();
    check("rd_ack_single", rd_ack, 0);
    check("rd_dat_held", rd_dat, 8'hA5);

    // Reset while the read is in flight
    rd_req = 1'b1; rd_adr = 5;
    cyc();
    check("rstrd_in_rd", ram_re, 1);
    rst = 1'b1; rd_req = 1'b0;
    #1;
    check("rstrd_ram_re", ram_re, 0);
    check("rstrd_ram_adr", ram_adr, 0);
    check("rstrd_rd_dat", rd_dat, 0);
    check("rstrd_rd_ack", rd_ack, 0);
    check("rstrd_wr_adr", wr_adr, 0);
    @(negedge clk) rst = 1'b0;
    ack_seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      ack_seen = ack_seen | rd_ack;
    end
    check("rstrd_no_ack", ack_seen, 0);
    cam_valid = 1'b1; cam_dat = 8'h77;
    #1;
    check("rstrd_idle_ready", cam_ready, 1);
    cyc();
    cam_valid = 1'b0;
    check("rstrd_write_adr0", ram_adr, 0);
    cyc();

    // Writer saturating with a reader waiting: MAX_WAIT writes, then the read
    rd_req = 1'b1; rd_adr = 5; cam_valid = 1'b1; cam_dat = 8'h44;
    k = 0; grant_at = -1; post = 0; acks = 0;
    for (int c = 0; c < 40 && post < 2; c++) begin
      #1;
      if (cam_ready) begin
        if (grant_at < 0) k++;
        else post++;
      end
      cyc();
      if (ram_re && grant_at < 0) grant_at = k;
      if (rd_ack) begin
        acks++;
        check("starve_rd_dat", rd_dat, 8'hA5);
        rd_req = 1'b0;
      end
    end
    cam_valid = 1'b0;
    check("starve_writes_before_read", grant_at, MAX_WAIT);
    check("starve_single_ack", acks, 1);
    check("starve_writes_resume", post, 2);
    cyc(); cyc();

    // Lone vsync rewinds the pointer without touching the RAM
    cam_vsync = 1'b1;
    cyc();
    cam_vsync = 1'b0;
    check("vs_alone_wr_adr", wr_adr, 0);
    check("vs_alone_we", ram_we, 0);
    n_ok = 0;
    for (int i = 0; i < 100; i++) begin
      push(8'(i), 1'b0, ok);
      n_ok += int'(ok);
    end
    check("vs_fill_pushes", n_ok, 100);
    check("vs_fill_wr_adr", wr_adr, 100);
    push(8'hC3, 1'b1, ok);
    check("vs_pix_ok", ok, 1);
    check("vs_pix_we", ram_we, 1);
    check("vs_pix_adr", ram_adr, 0);
    check("vs_pix_dat", ram_wdat, 8'hC3);
    check("vs_pix_wr_adr", wr_adr, 1);
    cyc();
    cam_vsync = 1'b1;
    cyc();
    cam_vsync = 1'b0;
    check("vs_alone2_wr_adr", wr_adr, 0);
    check("vs_alone2_we", ram_we, 0);

    // Frame wrap: last word of the frame
    n_ok = 0;
    for (int i = 0; i < D - 1; i++) begin
      push(8'(i + 3), 1'b0, ok);
      n_ok += int'(ok);
    end
    check("wrap_fill_pushes", n_ok, D - 1);
    check("wrap_pre_wr_adr", wr_adr, D - 1);
    check("wrap_pre_done", frame_done, 0);
    push(8'h5C, 1'b0, ok);
    check("wrap_we", ram_we, 1);
    check("wrap_adr", ram_adr, D - 1);
    check("wrap_dat", ram_wdat, 8'h5C);
    check("wrap_wr_adr", wr_adr, 0);
    check("wrap_done", frame_done, 1);
    cyc();
    check("wrap_done_pulse", frame_done, 0);

    // Randomized traffic against the transaction model
    for (int i = 0; i < D; i++) ref_mem[i] = ram_mem[i];
    exp_wr = '0; prev_acc = 1'b0; prev_used = '0; prev_dat = '0; hold = 1'b0;
    wcnt = 0; wait_c = 0; reads_done = 0; used = '0;
    for (int c = 0; c < 3000; c++) begin
      check("rnd_we", ram_we, prev_acc);
      if (prev_acc) begin
        check("rnd_we_adr", ram_adr, prev_used);
        check("rnd_we_dat", ram_wdat, prev_dat);
      end
      check("rnd_frame_done", frame_done, prev_acc && (prev_used == D - 1));
      check("rnd_wr_adr", wr_adr, exp_wr);
      if (rd_ack) begin
        check("rnd_ack_pending", rd_req, 1);
        check("rnd_rd_dat", rd_dat, ref_mem[rd_adr[IW-1:0]]);
        check("rnd_starve_bound", wcnt <= MAX_WAIT, 1);
        rd_req = 1'b0;
        reads_done++;
      end else if (rd_req) begin
        wait_c++;
        if (wait_c > 2 * MAX_WAIT + 6) begin
          check("rnd_rd_timeout", wait_c, 2 * MAX_WAIT + 6);
          rd_req = 1'b0;
        end
      end else if (c < 2970 && $urandom_range(0, 2) == 0) begin
        rd_req = 1'b1;
        rd_adr = ADR_W'($urandom_range(0, D - 1));
        wcnt = 0; wait_c = 0;
      end
      if (!hold) begin
        cam_valid = ($urandom_range(0, 3) != 0);
        cam_dat   = 8'($urandom);
      end
      cam_vsync = ($urandom_range(0, 199) == 0);
      #1;
      acc = cam_ready;
      check("rnd_ready_needs_valid", cam_ready & ~cam_valid, 0);
      check("rnd_no_back_to_back", acc & prev_acc, 0);
      if (acc) begin
        used = cam_vsync ? '0 : exp_wr;
        ref_mem[used[IW-1:0]] = cam_dat;
        exp_wr = (used == D - 1) ? '0 : used + 1'b1;
        if (rd_req) wcnt++;
      end else if (cam_vsync) begin
        exp_wr = '0;
      end
      hold      = cam_valid & ~acc;
      prev_acc  = acc;
      prev_used = used;
      prev_dat  = cam_dat;
      cyc();
    end
    cam_valid = 1'b0; cam_vsync = 1'b0;
    check("rnd_reads_done", reads_done > 50, 1);
    check("rnd_no_pending", rd_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
